bcd_seq_display: RTL and testbench
==================================

Name: bcd_seq_display

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock.
- Generalised in input width and digit count, with a start/busy/done handshake.
- Drives one 7-segment pattern per digit, with optional leading-zero blanking and an overflow indication.
- Sits between a binary source (switches, counter, ADC) and the board's seven-segment displays.

Parameters:
- BIT_SIZE, 10, width of the binary input (1..32).
- DIGITS, 4, number of BCD digits and displays (1..8).
- WIRE_SIZE, 4, bits per BCD digit (fixed at 4).
- SEGMENTOS, 7, segments per display (fixed at 7: a..g).

Ports:
- clk  input  1  system clock; everything is registered on its rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  conversion request, sampled in IDLE only.
- binary_in  input  BIT_SIZE  unsigned value, latched on the accepted start.
- blank_ceros  input  1  when 1, leading-zero digits are blanked; latched with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the result outputs update.
- overflow  output  1  result did not fit in DIGITS digits; held until the next done.
- bcd_out  output  WIRE_SIZE*DIGITS  packed BCD; digit 0 (units) is in bits [3:0].
- segmentos  output  SEGMENTOS*DIGITS  digit d occupies [d*7 +: 7]. Within each field the MSB is segment a and the LSB is segment g. Segments are active-low.

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high (rst).

Reset (rst=1 at a rising edge):
- State goes to IDLE.
- busy=0, done=0, overflow=0, bcd_out=0.
- segmentos: every digit blank (all 1s).
- rst has priority over every other input, including mid-conversion. The in-progress conversion is discarded and no done is issued.

State machine (IDLE, SHIFT, LOAD):
- IDLE:
  - If start=1, latch binary_in into a shift register and latch blank_ceros.
  - Clear the BCD work register and the sticky overflow flag.
  - Load the bit counter with BIT_SIZE, then go to SHIFT.
- SHIFT: one iteration per cycle.
  - First, add 3 to every work digit that is >=5.
  - Then shift {work, shift register} left by 1.
  - If the bit shifted out of the top work digit is 1, set the sticky overflow flag.
  - Decrement the counter; after BIT_SIZE iterations go to LOAD.
- LOAD:
  - Register the work value into bcd_out, the sticky flag into overflow, and the decoded patterns into segmentos.
  - Pulse done=1 for exactly this cycle's output; return to IDLE.

Timing and handshake:
- busy=1 in SHIFT and LOAD; busy=0 in the cycle done is high.
- Latency: start sampled at edge k, so outputs and done update at edge k+BIT_SIZE+1.
- start while busy=1 is ignored; no queueing.
- start held high re-triggers from IDLE, so the next conversion begins the cycle after done.
- Outputs are stable between done pulses.

Decode (active-low, a..g):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Blank = 1111111. Dash = 1111110.

Blanking:
- With the latched blank_ceros=1, digit d>0 is blanked iff it and all higher digits are 0.
- Digit 0 is never blanked.

Overflow:
- When overflow=1, every digit shows dash. bcd_out still holds the low DIGITS digits (value mod 10^DIGITS).

Test Plan:
1. BIT_SIZE=10, DIGITS=4: binary_in=1023, start pulse at edge k -> edge k+11: done=1 for 1 cycle, bcd_out=16'h1023, overflow=0, segmentos digits 3..0 = 1001111, 0000001, 0010010, 0000110.
2. binary_in=0, blank_ceros=1 -> bcd_out=0; digits 3..1 = 1111111; digit 0 = 0000001. Repeat with blank_ceros=0 -> all four digits 0000001.
3. DIGITS=3, binary_in=1000 -> overflow=1, all digits 1111110, bcd_out=12'h000. A following conversion of 999 -> overflow=0, bcd_out=12'h999.
4. Start 57, then pulse start with 300 two cycles later while busy=1 -> only one done, bcd_out=16'h0057; the second request is ignored.
5. Start 512, assert rst 4 cycles later -> no done; outputs at reset values; busy=0. Next start with 45 -> bcd_out=16'h0045 after 11 cycles.
6. start held high with binary_in stepping 0..20 -> back-to-back done pulses 12 cycles apart; each bcd_out matches the value latched at its start.

Source files
------------

// File: rtl/bcd_seq_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// per-digit active-low 7-segment decode, leading-zero blanking and overflow dashes.
module bcd_seq_display #(
  parameter int BIT_SIZE  = 10,
  parameter int DIGITS    = 4,
  parameter int WIRE_SIZE = 4,
  parameter int SEGMENTOS = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [BIT_SIZE-1:0]            binary_in,
  input  logic                           blank_ceros,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [WIRE_SIZE*DIGITS-1:0]    bcd_out,
  output logic [SEGMENTOS*DIGITS-1:0]    segmentos,
  output logic [1:0]                     o_dbg_state
);

  localparam int WD = WIRE_SIZE * DIGITS;
  localparam int SD = SEGMENTOS * DIGITS;
  localparam int CW = $clog2(BIT_SIZE + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Handshake: start is accepted only in IDLE; busy covers SHIFT and LOAD;
  // done is a single-cycle pulse coinciding with the output update, busy=0 then.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [BIT_SIZE-1:0]   r_shift;
  logic [WD-1:0]         r_work;
  logic [CW-1:0]         r_cnt;
  logic                  r_blank;
  logic                  r_ovf_sticky;
  logic [WD-1:0]         r_bcd;
  logic                  r_ovf;
  logic [SD-1:0]         r_seg;
  logic                  r_done;

  logic [WD-1:0]         w_adj;
  logic [WIRE_SIZE-1:0]  w_adj_digit;
  logic [SD-1:0]         w_seg_next;
  logic [WIRE_SIZE-1:0]  w_seg_digit;
  logic                  w_zero_above;

  function automatic logic [6:0] f_decode(input logic [WIRE_SIZE-1:0] d);
    case (d)
      4'd0:    f_decode = 7'b0000001;
      4'd1:    f_decode = 7'b1001111;
      4'd2:    f_decode = 7'b0010010;
      4'd3:    f_decode = 7'b0000110;
      4'd4:    f_decode = 7'b1001100;
      4'd5:    f_decode = 7'b0100100;
      4'd6:    f_decode = 7'b0100000;
      4'd7:    f_decode = 7'b0001111;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0000100;
      default: f_decode = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (r_cnt == CW'(1)) w_next_state = LOAD;
      LOAD:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Add-3 correction applied to every work digit before the shift.
  always_comb begin
    w_adj       = '0;
    w_adj_digit = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_adj_digit = r_work[d*WIRE_SIZE +: WIRE_SIZE];
      if (w_adj_digit >= WIRE_SIZE'(5)) w_adj_digit = w_adj_digit + WIRE_SIZE'(3);
      w_adj[d*WIRE_SIZE +: WIRE_SIZE] = w_adj_digit;
    end
  end

  // Decode walks from the top digit down so zero_above tracks leading zeros.
  always_comb begin
    w_seg_next   = '1;
    w_seg_digit  = '0;
    w_zero_above = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_seg_digit  = r_work[d*WIRE_SIZE +: WIRE_SIZE];
      w_zero_above = w_zero_above & (w_seg_digit == '0);
      if (r_ovf_sticky)
        w_seg_next[d*SEGMENTOS +: SEGMENTOS] = SEG_DASH;
      else if ((d > 0) && r_blank && w_zero_above)
        w_seg_next[d*SEGMENTOS +: SEGMENTOS] = SEG_BLANK;
      else
        w_seg_next[d*SEGMENTOS +: SEGMENTOS] = f_decode(w_seg_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_work       <= '0;
      r_cnt        <= '0;
      r_blank      <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_bcd        <= '0;
      r_ovf        <= 1'b0;
      r_seg        <= '1;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift      <= binary_in;
            r_blank      <= blank_ceros;
            r_work       <= '0;
            r_ovf_sticky <= 1'b0;
            r_cnt        <= CW'(BIT_SIZE);
          end
        end
        SHIFT: begin
          r_work <= {w_adj[WD-2:0], r_shift[BIT_SIZE-1]};
          r_shift <= r_shift << 1;
          // A carry out of the top digit means the value needs another digit.
          if (w_adj[WD-1]) r_ovf_sticky <= 1'b1;
          r_cnt <= r_cnt - CW'(1);
        end
        LOAD: begin
          r_bcd  <= r_work;
          r_ovf  <= r_ovf_sticky;
          r_seg  <= w_seg_next;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == SHIFT) || (r_state == LOAD);
  assign done        = r_done;
  assign overflow    = r_ovf;
  assign bcd_out     = r_bcd;
  assign segmentos   = r_seg;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_seq_display.sv
// Self-checking bench for bcd_seq_display: a 4-digit and a 3-digit instance,
// expected results queued at stimulus time and compared when done pulses.
module tb_bcd_seq_display;

  localparam int W = 89;

  logic clk = 1'b0;
  logic rst;
  logic start, blank_ceros;
  logic [9:0] binary_in;
  logic busy, done, overflow;
  logic [15:0] bcd_out;
  logic [27:0] segmentos;
  logic [1:0] dbg_state;

  logic start3, blank3;
  logic [9:0] bin3;
  logic busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [20:0] seg3;
  logic [1:0] dbg_state3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];

  bcd_seq_display u_dut (
    .clk(clk), .rst(rst), .start(start), .binary_in(binary_in),
    .blank_ceros(blank_ceros), .busy(busy), .done(done), .overflow(overflow),
    .bcd_out(bcd_out), .segmentos(segmentos), .o_dbg_state(dbg_state)
  );

  bcd_seq_display #(.BIT_SIZE(10), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .binary_in(bin3),
    .blank_ceros(blank3), .busy(busy3), .done(done3), .overflow(ovf3),
    .bcd_out(bcd3), .segmentos(seg3), .o_dbg_state(dbg_state3)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input int dig);
    case (dig)
      0: seg_of = 7'b0000001;  1: seg_of = 7'b1001111;
      2: seg_of = 7'b0010010;  3: seg_of = 7'b0000110;
      4: seg_of = 7'b1001100;  5: seg_of = 7'b0100100;
      6: seg_of = 7'b0100000;  7: seg_of = 7'b0001111;
      8: seg_of = 7'b0000000;  9: seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Reference model: packs {bcd (32), overflow, segments (56)}.
  function automatic logic [W-1:0] model(input int v, input bit blk, input int nd);
    int p, pd, low, dig;
    logic ovf;
    logic [31:0] b;
    logic [55:0] s;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    ovf = (v >= p);
    low = v % p;
    b = '0;
    s = '0;
    pd = 1;
    for (int d = 0; d < nd; d++) begin
      dig = (low / pd) % 10;
      b[d*4 +: 4] = 4'(dig);
      if (ovf) s[d*7 +: 7] = 7'b1111110;
      else if (d > 0 && blk && (low / pd) == 0) s[d*7 +: 7] = 7'b1111111;
      else s[d*7 +: 7] = seg_of(dig);
      pd = pd * 10;
    end
    return {b, ovf, s};
  endfunction

  // Driver tasks
  task automatic drive_conv(input int v, input bit blk);
    @(negedge clk);
    binary_in = 10'(v);
    blank_ceros = blk;
    start = 1'b1;
    exp_q.push_back(model(v, blk, 4));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_conv3(input int v, input bit blk);
    @(negedge clk);
    bin3 = 10'(v);
    blank3 = blk;
    start3 = 1'b1;
    exp3_q.push_back(model(v, blk, 3));
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done3(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done3 === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h want 0000", bcd_out); end
    checks++; if (segmentos !== {28{1'b1}}) begin errors++; $display("FAIL reset_seg: got %b want all ones", segmentos); end
    checks++; if (seg3 !== {21{1'b1}}) begin errors++; $display("FAIL reset_seg3: got %b want all ones", seg3); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_max;
    int cyc; bit ok; logic [W-1:0] e, g;
    drive_conv(1023, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL max_busy: got %b want 1", busy); end
    wait_done(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL max_timeout: no done within 40 cycles"); end
    if (ok) begin
      checks++; if (cyc !== 11) begin errors++; $display("FAIL max_latency: got %0d want 11", cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL max_busy_at_done: got %b want 0", busy); end
      e = exp_q.pop_front();
      g = {32'(bcd_out), overflow, 56'(segmentos)};
      checks++; if (g !== e) begin errors++; $display("FAIL max_result: got %h want %h", g, e); end
      checks++;
      if (segmentos !== {7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110}) begin
        errors++; $display("FAIL max_seg: got %b want 1001111000000100100100000110", segmentos);
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL max_done_width: got %b want 0", done); end
    end else exp_q.delete();
  endtask

  task automatic test_zero;
    int cyc; bit ok; logic [W-1:0] e, g;
    for (int b = 1; b >= 0; b--) begin
      drive_conv(0, b[0]);
      wait_done(cyc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: blank=%0d", b); end
      if (ok) begin
        e = exp_q.pop_front();
        g = {32'(bcd_out), overflow, 56'(segmentos)};
        checks++; if (g !== e) begin errors++; $display("FAIL zero_result: blank=%0d got %h want %h", b, g, e); end
        checks++;
        if (b == 1 && segmentos !== {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}) begin
          errors++; $display("FAIL zero_blank_seg: got %b", segmentos);
        end else if (b == 0 && segmentos !== {4{7'b0000001}}) begin
          errors++; $display("FAIL zero_noblank_seg: got %b", segmentos);
        end
      end else exp_q.delete();
    end
  endtask

  task automatic test_overflow;
    int cyc; bit ok; logic [W-1:0] e, g;
    drive_conv3(1000, 1'b0);
    wait_done3(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: no done3"); end
    if (ok) begin
      e = exp3_q.pop_front();
      g = {32'(bcd3), ovf3, 56'(seg3)};
      checks++; if (g !== e) begin errors++; $display("FAIL ovf_result: got %h want %h", g, e); end
      checks++; if (ovf3 !== 1'b1 || seg3 !== {3{7'b1111110}} || bcd3 !== 12'h000) begin
        errors++; $display("FAIL ovf_fields: ovf=%b seg=%b bcd=%h want 1 dashes 000", ovf3, seg3, bcd3);
      end
    end else exp3_q.delete();
    drive_conv3(999, 1'b0);
    wait_done3(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf999_timeout: no done3"); end
    if (ok) begin
      e = exp3_q.pop_front();
      g = {32'(bcd3), ovf3, 56'(seg3)};
      checks++; if (g !== e) begin errors++; $display("FAIL ovf999_result: got %h want %h", g, e); end
      checks++; if (ovf3 !== 1'b0 || bcd3 !== 12'h999) begin
        errors++; $display("FAIL ovf999_fields: ovf=%b bcd=%h want 0 999", ovf3, bcd3);
      end
    end else exp3_q.delete();
  endtask

  task automatic test_ignore_busy;
    int n_done; logic [W-1:0] e, g;
    n_done = 0;
    drive_conv(57, 1'b0);
    binary_in = 10'd300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_ignore_count: got %0d dones want 1", n_done); end
    e = exp_q.pop_front();
    g = {32'(bcd_out), overflow, 56'(segmentos)};
    checks++; if (g !== e) begin errors++; $display("FAIL busy_ignore_result: got %h want %h", g, e); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int cyc, n_done; bit ok; logic [W-1:0] e, g;
    drive_conv(512, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: busy=%b done=%b ovf=%b want 0 0 0", busy, done, overflow);
    end
    checks++; if (bcd_out !== 16'h0 || segmentos !== {28{1'b1}}) begin
      errors++; $display("FAIL midrst_outputs: bcd=%h seg=%b want 0000 all ones", bcd_out, segmentos);
    end
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d dones want 0", n_done); end
    drive_conv(45, 1'b0);
    wait_done(cyc, ok);
    checks++; if (!ok || cyc !== 11) begin errors++; $display("FAIL midrst_45_latency: ok=%0d got %0d want 11", ok, cyc); end
    if (ok) begin
      e = exp_q.pop_front();
      g = {32'(bcd_out), overflow, 56'(segmentos)};
      checks++; if (g !== e) begin errors++; $display("FAIL midrst_45_result: got %h want %h", g, e); end
    end else exp_q.delete();
  endtask

  task automatic test_random;
    int cyc, v; bit ok, blk; logic [W-1:0] e, g;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 1023));
      blk = 1'($urandom_range(0, 1));
      drive_conv(v, blk);
      wait_done(cyc, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: value %0d", v); end
      if (ok) begin
        e = exp_q.pop_front();
        g = {32'(bcd_out), overflow, 56'(segmentos)};
        checks++; if (g !== e) begin errors++; $display("FAIL rand_result: v=%0d blk=%0d got %h want %h", v, blk, g, e); end
      end else exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit ok; logic [W-1:0] e, g;
    @(negedge clk);
    start = 1'b1;
    blank_ceros = 1'b0;
    binary_in = 10'd0;
    exp_q.push_back(model(0, 1'b0, 4));
    for (int v = 0; v <= 20; v++) begin
      wait_done(cyc, ok);
      checks++; if (!ok || cyc !== 12) begin errors++; $display("FAIL b2b_spacing: v=%0d ok=%0d got %0d want 12", v, ok, cyc); end
      if (!ok) begin exp_q.delete(); break; end
      e = exp_q.pop_front();
      g = {32'(bcd_out), overflow, 56'(segmentos)};
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_result: v=%0d got %h want %h", v, g, e); end
      if (v < 20) begin
        binary_in = 10'(v + 1);
        exp_q.push_back(model(v + 1, 1'b0, 4));
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; blank_ceros = 1'b0; binary_in = '0;
    start3 = 1'b0; blank3 = 1'b0; bin3 = '0;
    test_reset;
    test_max;
    test_zero;
    test_overflow;
    test_ignore_busy;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
